uart_frame_decoder: RTL
=======================

Name: uart_frame_decoder

Overview:
Parametrised successor to the UART byte-pack decoder. Reassembles framed UART packets (sync byte, payload, optional checksum) into output-pattern, frequency-pattern and control fields for the serial-out channels. Adds sync hunting, inter-byte timeout, checksum validation, error reporting and held (registered) outputs. Sits between uart_rx (byte + done tick) and the channel controller.

Parameters:
DATA_BIT, 32, width of output and frequency patterns; multiple of 8, 8..64
SEL_BIT, 4, width of channel-select field; 1..4
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLK, 100000, max clk cycles between bytes inside a frame; >=2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_data  in  8  received UART byte
i_rx_done_tick  in  1  one-cycle strobe, i_data valid
o_output_pattern  out  DATA_BIT  last valid output pattern (held)
o_freq_pattern  out  DATA_BIT  last valid frequency pattern (held)
o_start  out  1  control bit0 (held)
o_stop  out  1  control bit1 (held)
o_mode  out  1  control bit2 (held)
o_sel_out  out  SEL_BIT  control bits[4+SEL_BIT-1:4] (held)
o_done_tick  out  1  one-cycle strobe, outputs just updated
o_err_tick  out  1  one-cycle strobe, frame dropped
o_err_code  out  2  01 checksum fail, 10 timeout; held until next error tick
o_busy  out  1  high while not in S_HUNT

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk): all outputs 0, state S_HUNT, counters and checksum accumulator cleared. Reset mid-frame discards the partial frame; no tick is issued.
- Frame: SYNC_BYTE, then PAY_NUM = 2*DATA_BIT/8 + 1 payload bytes, then one checksum byte (CHECKSUM_EN only).
- Payload order, little-endian: bytes 0..DATA_BIT/8-1 form the output pattern (byte 0 = bits[7:0]), next DATA_BIT/8 form the frequency pattern, last byte is the control byte.
- Bytes are accepted only on i_rx_done_tick.
- States:
  - S_HUNT: non-SYNC bytes discarded silently. SYNC -> S_PAYLOAD, byte count = 0, sum = 0.
  - S_PAYLOAD: each byte shifted into the shift register, sum += byte (mod 256), count+1. On byte PAY_NUM-1 -> S_CHECK (CHECKSUM_EN) or S_DONE.
  - S_CHECK: next byte is compared with sum. Equal -> S_DONE. Unequal -> o_err_tick, o_err_code=01, -> S_HUNT.
  - S_DONE: one cycle. Latch all held outputs from the shift register, o_done_tick=1, -> S_HUNT.
- Latency: o_done_tick and the updated outputs appear exactly 1 clk after the final byte's tick. o_err_tick (checksum) appears 1 clk after the checksum byte.
- SYNC_BYTE inside payload/checksum is data; no re-sync.
- Timeout: gap counter cleared on every accepted byte and in S_HUNT. In S_PAYLOAD/S_CHECK, counter reaching TIMEOUT_CLK-1 -> o_err_tick, o_err_code=10, -> S_HUNT. If i_rx_done_tick coincides with the terminal count, the byte wins and no timeout occurs.
- Held outputs change only in S_DONE; errors never modify them.
- Control bits 3 and unused upper bits are ignored.
- o_done_tick and o_err_tick are never high in the same cycle.

Optional Feature:
CHECKSUM_EN. Defined: S_CHECK present; frame carries a trailing 8-bit sum-mod-256 of the payload bytes; mismatch raises error 01. Undefined: no checksum byte, S_DONE follows the last payload byte directly, error 01 can never occur.

Test Plan:
1. CHECKSUM_EN, defaults: A5 78 56 34 12 DD CC BB AA 25 47 -> 1 clk after last tick: done_tick=1, output=0x12345678, freq=0xAABBCCDD, start=1, stop=0, mode=1, sel=2.
2. Same frame, checksum 0x48 -> err_tick, err_code=01; held outputs unchanged from the prior frame (all 0 after reset).
3. Leading garbage 00 FF 3C, then the frame from test 1 -> no ticks during the garbage; single done_tick with test-1 values.
4. TIMEOUT_CLK=16: A5 78 56, then idle -> err_tick exactly 16 clks after the 56 tick, err_code=10, busy=0. A subsequent full frame decodes correctly.
5. Payload containing A5 (output pattern 0x00A50000, checksum recomputed) -> decoded as data, done_tick, output=0x00A50000.
6. Assert rst_n low mid-payload, then release and send the test-1 frame -> no tick from the aborted frame; test-1 frame decodes correctly.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: reassembles framed UART packets into held output-pattern,
// frequency-pattern and control fields for the serial-out channel controller.
// Frame: SYNC_BYTE, PAY_NUM = 2*DATA_BIT/8 + 1 payload bytes (little-endian),
// then an optional sum-mod-256 checksum byte.
// Optional feature macro: CHECKSUM_EN (define to expect and verify the checksum byte).
module uart_frame_decoder #(
    parameter int unsigned DATA_BIT    = 32,
    parameter int unsigned SEL_BIT     = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CLK = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_mode,
    output logic [SEL_BIT-1:0]  o_sel_out,
    output logic                o_done_tick,
    output logic                o_err_tick,
    output logic [1:0]          o_err_code,
    output logic                o_busy
);

    localparam int unsigned PAY_NUM = 2 * DATA_BIT / 8 + 1;
    localparam int unsigned SH_W    = PAY_NUM * 8;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CLK);
    localparam int unsigned BC_W    = $clog2(PAY_NUM + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CLK - 1);
    localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(PAY_NUM - 1);
    localparam logic [1:0]       ERR_CSUM    = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Running checksum: payload bytes summed modulo 256.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t                state_r;
    logic [SH_W-1:0]       shreg_r;
    logic [7:0]            sum_r;
    logic [BC_W-1:0]       byte_cnt_r;
    logic [CNT_W-1:0]      gap_cnt_r;
    logic [DATA_BIT-1:0]   out_pat_r;
    logic [DATA_BIT-1:0]   freq_pat_r;
    logic                  start_r;
    logic                  stop_r;
    logic                  mode_r;
    logic [SEL_BIT-1:0]    sel_r;
    logic                  done_tick_r;
    logic                  err_tick_r;
    logic [1:0]            err_code_r;
    logic                  busy_r;

    // First payload byte ends up in the low byte after all bytes are shifted in.
    logic [SH_W-1:0] shifted_s;
    logic [SH_W-1:0] frame_s;
    logic [7:0]      ctrl_s;
    logic            unused_s;

    assign shifted_s = {i_data, shreg_r[SH_W-1:8]};
`ifdef CHECKSUM_EN
    assign frame_s   = shreg_r;
`else
    assign frame_s   = shifted_s;
`endif
    assign ctrl_s    = frame_s[SH_W-1 -: 8];
    // Control bit 3 and bits above the select field carry no meaning.
    assign unused_s  = ^{ctrl_s, shreg_r[7:0]};

    // Frame FSM: sync hunt, payload collection, checksum, output latch, timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_HUNT;
            shreg_r     <= '0;
            sum_r       <= 8'h00;
            byte_cnt_r  <= '0;
            gap_cnt_r   <= '0;
            out_pat_r   <= '0;
            freq_pat_r  <= '0;
            start_r     <= 1'b0;
            stop_r      <= 1'b0;
            mode_r      <= 1'b0;
            sel_r       <= '0;
            done_tick_r <= 1'b0;
            err_tick_r  <= 1'b0;
            err_code_r  <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            done_tick_r <= 1'b0;
            err_tick_r  <= 1'b0;
            case (state_r)
                // S_DONE lasts one cycle and hunts like S_HUNT so no byte is lost.
                S_HUNT, S_DONE: begin
                    gap_cnt_r <= '0;
                    if (i_rx_done_tick && (i_data == SYNC_BYTE)) begin
                        state_r    <= S_PAYLOAD;
                        busy_r     <= 1'b1;
                        byte_cnt_r <= '0;
                        sum_r      <= 8'h00;
                    end else begin
                        state_r    <= S_HUNT;
                        busy_r     <= 1'b0;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_done_tick) begin
                        gap_cnt_r  <= '0;
                        shreg_r    <= shifted_s;
                        sum_r      <= sum8(sum_r, i_data);
                        byte_cnt_r <= byte_cnt_r + BC_W'(1);
                        if (byte_cnt_r == BC_LAST) begin
`ifdef CHECKSUM_EN
                            state_r     <= S_CHECK;
`else
                            state_r     <= S_DONE;
                            out_pat_r   <= frame_s[DATA_BIT-1:0];
                            freq_pat_r  <= frame_s[2*DATA_BIT-1:DATA_BIT];
                            start_r     <= ctrl_s[0];
                            stop_r      <= ctrl_s[1];
                            mode_r      <= ctrl_s[2];
                            sel_r       <= ctrl_s[4 +: SEL_BIT];
                            done_tick_r <= 1'b1;
`endif
                        end else begin
                            state_r <= S_PAYLOAD;
                        end
                    end else if (gap_cnt_r == CNT_LAST) begin
                        state_r    <= S_HUNT;
                        busy_r     <= 1'b0;
                        err_tick_r <= 1'b1;
                        err_code_r <= ERR_TIMEOUT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (i_rx_done_tick) begin
                        gap_cnt_r <= '0;
                        if (i_data == sum_r) begin
                            state_r     <= S_DONE;
                            out_pat_r   <= frame_s[DATA_BIT-1:0];
                            freq_pat_r  <= frame_s[2*DATA_BIT-1:DATA_BIT];
                            start_r     <= ctrl_s[0];
                            stop_r      <= ctrl_s[1];
                            mode_r      <= ctrl_s[2];
                            sel_r       <= ctrl_s[4 +: SEL_BIT];
                            done_tick_r <= 1'b1;
                        end else begin
                            state_r    <= S_HUNT;
                            busy_r     <= 1'b0;
                            err_tick_r <= 1'b1;
                            err_code_r <= ERR_CSUM;
                        end
                    end else if (gap_cnt_r == CNT_LAST) begin
                        state_r    <= S_HUNT;
                        busy_r     <= 1'b0;
                        err_tick_r <= 1'b1;
                        err_code_r <= ERR_TIMEOUT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= S_HUNT;
                    busy_r    <= 1'b0;
                    gap_cnt_r <= '0;
                end
            endcase
        end
    end

    assign o_output_pattern = out_pat_r;
    assign o_freq_pattern   = freq_pat_r;
    assign o_start          = start_r;
    assign o_stop           = stop_r;
    assign o_mode           = mode_r;
    assign o_sel_out        = sel_r;
    assign o_done_tick      = done_tick_r;
    assign o_err_tick       = err_tick_r;
    assign o_err_code       = err_code_r;
    assign o_busy           = busy_r;

endmodule
